// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - 4-wide register rename stage with RAT, intra-group bypass and output pipe register
module rename_stage #(
  parameter int ARCH_WIDTH = 5,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_slot_vld,
  input  logic [4*ARCH_WIDTH-1:0] in_rs1,
  input  logic [4*ARCH_WIDTH-1:0] in_rs2,
  input  logic [4*ARCH_WIDTH-1:0] in_rd,
  input  logic [3:0]              in_rd_we,
  output logic [3:0]              alloc_req,
  input  logic [4*TAG_WIDTH-1:0]  alloc_tag,
  input  logic                    fl_empty,
  input  logic [3:0]              cmt_vld,
  input  logic [4*ARCH_WIDTH-1:0] cmt_rd,
  input  logic [4*TAG_WIDTH-1:0]  cmt_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_slot_vld,
  output logic [4*TAG_WIDTH-1:0]  out_rs1_tag,
  output logic [3:0]              out_rs1_ren,
  output logic [4*TAG_WIDTH-1:0]  out_rs2_tag,
  output logic [3:0]              out_rs2_ren,
  output logic [4*TAG_WIDTH-1:0]  out_rd_tag,
  output logic [3:0]              out_rd_alloc,
  output logic [4*ARCH_WIDTH-1:0] out_rd
);

  localparam int NREG = 1 << ARCH_WIDTH;

  logic [NREG-1:0]      rat_vld;
  logic [TAG_WIDTH-1:0] rat_tag [NREG];

  logic [3:0]             need;
  logic [2:0]             n_need;
  logic [1:0]             idx [4];
  logic [TAG_WIDTH-1:0]   dtag [4];
  logic                   pipe_ok;
  logic                   fire;
  logic [4*TAG_WIDTH-1:0] nxt_rs1_tag;
  logic [4*TAG_WIDTH-1:0] nxt_rs2_tag;
  logic [4*TAG_WIDTH-1:0] nxt_rd_tag;
  logic [3:0]             nxt_rs1_ren;
  logic [3:0]             nxt_rs2_ren;

  // Slot k takes the free-list port equal to the number of earlier allocating slots
  always_comb begin
    need   = '0;
    n_need = '0;
    for (int k = 0; k < 4; k++) begin
      need[k] = in_slot_vld[k] & in_rd_we[k] & (in_rd[k*ARCH_WIDTH +: ARCH_WIDTH] != '0);
      idx[k]  = n_need[1:0];
      if (need[k]) n_need = n_need + 3'd1;
      dtag[k] = need[k] ? alloc_tag[int'(idx[k])*TAG_WIDTH +: TAG_WIDTH] : '0;
    end
  end

  assign pipe_ok  = in_valid & (~out_valid | out_ready) & ~flush;
  assign fire     = pipe_ok & ~fl_empty;
  assign in_ready = (~out_valid | out_ready) & ~flush & ~fl_empty;

  always_comb begin
    alloc_req = 4'b0000;
    if (pipe_ok) begin
      case (n_need)
        3'd1:    alloc_req = 4'b0001;
        3'd2:    alloc_req = 4'b0011;
        3'd3:    alloc_req = 4'b0111;
        3'd4:    alloc_req = 4'b1111;
        default: alloc_req = 4'b0000;
      endcase
    end
  end

  // Ascending scan over earlier slots so the nearest producer is the last to write
  always_comb begin
    nxt_rs1_tag = '0;
    nxt_rs2_tag = '0;
    nxt_rs1_ren = '0;
    nxt_rs2_ren = '0;
    for (int k = 0; k < 4; k++) begin
      logic [ARCH_WIDTH-1:0] s1;
      logic [ARCH_WIDTH-1:0] s2;
      s1 = in_rs1[k*ARCH_WIDTH +: ARCH_WIDTH];
      s2 = in_rs2[k*ARCH_WIDTH +: ARCH_WIDTH];
      nxt_rs1_ren[k] = rat_vld[s1];
      nxt_rs1_tag[k*TAG_WIDTH +: TAG_WIDTH] = rat_vld[s1] ? rat_tag[s1] : '0;
      nxt_rs2_ren[k] = rat_vld[s2];
      nxt_rs2_tag[k*TAG_WIDTH +: TAG_WIDTH] = rat_vld[s2] ? rat_tag[s2] : '0;
      for (int j = 0; j < k; j++) begin
        if (need[j] && in_rd[j*ARCH_WIDTH +: ARCH_WIDTH] == s1) begin
          nxt_rs1_ren[k] = 1'b1;
          nxt_rs1_tag[k*TAG_WIDTH +: TAG_WIDTH] = dtag[j];
        end
        if (need[j] && in_rd[j*ARCH_WIDTH +: ARCH_WIDTH] == s2) begin
          nxt_rs2_ren[k] = 1'b1;
          nxt_rs2_tag[k*TAG_WIDTH +: TAG_WIDTH] = dtag[j];
        end
      end
      if (s1 == '0) begin
        nxt_rs1_ren[k] = 1'b0;
        nxt_rs1_tag[k*TAG_WIDTH +: TAG_WIDTH] = '0;
      end
      if (s2 == '0) begin
        nxt_rs2_ren[k] = 1'b0;
        nxt_rs2_tag[k*TAG_WIDTH +: TAG_WIDTH] = '0;
      end
      nxt_rd_tag[k*TAG_WIDTH +: TAG_WIDTH] = dtag[k];
    end
  end

  // Commit clears are issued first so a same-cycle rename of the entry overrides them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rat_vld <= '0;
      for (int i = 0; i < NREG; i++) rat_tag[i] <= '0;
    end else if (flush) begin
      rat_vld <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cmt_vld[k] && rat_vld[cmt_rd[k*ARCH_WIDTH +: ARCH_WIDTH]] &&
            rat_tag[cmt_rd[k*ARCH_WIDTH +: ARCH_WIDTH]] == cmt_tag[k*TAG_WIDTH +: TAG_WIDTH])
          rat_vld[cmt_rd[k*ARCH_WIDTH +: ARCH_WIDTH]] <= 1'b0;
      end
      if (fire) begin
        for (int k = 0; k < 4; k++) begin
          if (need[k]) begin
            rat_vld[in_rd[k*ARCH_WIDTH +: ARCH_WIDTH]] <= 1'b1;
            rat_tag[in_rd[k*ARCH_WIDTH +: ARCH_WIDTH]] <= dtag[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_slot_vld <= '0;
      out_rs1_tag  <= '0;
      out_rs1_ren  <= '0;
      out_rs2_tag  <= '0;
      out_rs2_ren  <= '0;
      out_rd_tag   <= '0;
      out_rd_alloc <= '0;
      out_rd       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_slot_vld <= in_slot_vld;
      out_rs1_tag  <= nxt_rs1_tag;
      out_rs1_ren  <= nxt_rs1_ren;
      out_rs2_tag  <= nxt_rs2_tag;
      out_rs2_ren  <= nxt_rs2_ren;
      out_rd_tag   <= nxt_rd_tag;
      out_rd_alloc <= need;
      out_rd       <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
